memory_game_ctrl: RTL

- Board-side controller for the two-player memory (pairs) game.
- Holds a 16-cell board of 8 card pairs and moves a cursor.
- Accepts player button presses and produces the per-selection handshake (select, state, empty, player) consumed by the turn/score block.
- Receives the scorer's 2-bit result code, marks matched pairs, alternates turns, enforces a turn timeout and drives display status.

---
 rtl/memory_game_if.sv | 29 ++
 rtl/memory_game_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/memory_game_if.sv
// Board-side handshake bundle between the memory game controller and its
// environment: button pulses and scorer result in, selection strobe and
// display status out.
interface memory_game_if;
    logic        btn_next;
    logic        btn_sel;
    logic [1:0]  res;
    logic        select;
    logic [3:0]  state;
    logic        empty;
    logic        player;
    logic [3:0]  cursor;
    logic [15:0] shown;
    logic [15:0] matched;
    logic        game_over;
    logic        tie;

    // Environment side: drives buttons and scorer result, observes status.
    modport master (
        output btn_next, btn_sel, res,
        input  select, state, empty, player, cursor, shown, matched, game_over, tie
    );

    // Controller side.
    modport slave (
        input  btn_next, btn_sel, res,
        output select, state, empty, player, cursor, shown, matched, game_over, tie
    );
endinterface

// File: rtl/memory_game_ctrl.sv
// Memory (pairs) game board controller: cursor, two-pick turns, reveal
// timer, pair resolution, turn timeout and end-of-game handling.
//
// state   | meaning
// --------+------------------------------------------------------------
// WAIT1   | waiting for the first pick of the turn
// WAIT2   | first card face-up, waiting for a distinct second pick
// SHOW    | both cards face-up for SHOW_CYCLES cycles
// RESOLVE | one cycle: mark pair matched, or hide both and pass turn
// DONE    | game finished; everything frozen until reset
module memory_game_ctrl #(
    parameter logic [63:0] LAYOUT      = 64'h7654_3210_0123_4567,
    parameter int          SHOW_CYCLES = 50_000_000,
    parameter int          TIMEOUT     = 500_000_000
) (
    input  logic          clk,
    input  logic          rst,
    memory_game_if.slave  bus
);
    typedef enum logic [2:0] {S_WAIT1, S_WAIT2, S_SHOW, S_RESOLVE, S_DONE} fsm_t;

    // One shared down-counter: reveal time in SHOW, idle time in WAIT1/WAIT2.
    localparam logic [31:0] SHOW_LOAD = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] TO_LOAD   = 32'(TIMEOUT - 1);

    fsm_t        fsm_q, fsm_d;
    logic [3:0]  cursor_q, cursor_d;
    logic [3:0]  idx1_q, idx1_d;
    logic [3:0]  idx2_q, idx2_d;
    logic [3:0]  card_q, card_d;
    logic [15:0] shown_q, shown_d;
    logic [15:0] matched_q, matched_d;
    logic        player_q, player_d;
    logic        select_q, select_d;
    logic        game_over_q, game_over_d;
    logic        tie_q, tie_d;
    logic [31:0] tmr_q, tmr_d;

    logic        in_wait, res_end, cell_hidden, pick1, pick2, nxt_ok;
    logic        to_hit, show_done, resolve_go, pair_eq;
    logic [3:0]  cur_id, id1, id2;
    logic [15:0] matched_upd;

    assign in_wait     = (fsm_q == S_WAIT1) || (fsm_q == S_WAIT2);
    assign res_end     = bus.res[1] && (fsm_q != S_DONE);
    assign cur_id      = LAYOUT[{cursor_q, 2'b00} +: 4];
    assign id1         = LAYOUT[{idx1_q, 2'b00} +: 4];
    assign id2         = LAYOUT[{idx2_q, 2'b00} +: 4];
    assign pair_eq     = (id1 == id2);
    assign cell_hidden = !shown_q[cursor_q] && !matched_q[cursor_q];
    assign pick1       = (fsm_q == S_WAIT1) && bus.btn_sel && cell_hidden && !res_end;
    assign pick2       = (fsm_q == S_WAIT2) && bus.btn_sel && cell_hidden &&
                         (cursor_q != idx1_q) && !res_end;
    assign nxt_ok      = bus.btn_next && (fsm_q != S_DONE);
    // Any accepted button press restarts the idle count, so it also beats the timeout.
    assign to_hit      = in_wait && (tmr_q == 32'd0) && !nxt_ok && !pick1 && !pick2 && !res_end;
    assign show_done   = (fsm_q == S_SHOW) && (tmr_q == 32'd0);
    assign resolve_go  = (fsm_q == S_RESOLVE) && !res_end;
    assign matched_upd = matched_q |
                         ((resolve_go && pair_eq) ? ((16'd1 << idx1_q) | (16'd1 << idx2_q)) : 16'd0);

    // State and datapath registers; the idle timer resets to a full TIMEOUT window.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_WAIT1;
            cursor_q    <= 4'd0;
            idx1_q      <= 4'd0;
            idx2_q      <= 4'd0;
            card_q      <= 4'd0;
            shown_q     <= 16'd0;
            matched_q   <= 16'd0;
            player_q    <= 1'b0;
            select_q    <= 1'b0;
            game_over_q <= 1'b0;
            tie_q       <= 1'b0;
            tmr_q       <= TO_LOAD;
        end else begin
            fsm_q       <= fsm_d;
            cursor_q    <= cursor_d;
            idx1_q      <= idx1_d;
            idx2_q      <= idx2_d;
            card_q      <= card_d;
            shown_q     <= shown_d;
            matched_q   <= matched_d;
            player_q    <= player_d;
            select_q    <= select_d;
            game_over_q <= game_over_d;
            tie_q       <= tie_d;
            tmr_q       <= tmr_d;
        end
    end

    // Next-state: scorer end codes win over picks, timeouts and resolution.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_WAIT1: begin
                if (res_end)    fsm_d = S_DONE;
                else if (pick1) fsm_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (res_end)     fsm_d = S_DONE;
                else if (pick2)  fsm_d = S_SHOW;
                else if (to_hit) fsm_d = S_WAIT1;
            end
            S_SHOW: begin
                if (res_end)        fsm_d = S_DONE;
                else if (show_done) fsm_d = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (res_end || (&matched_upd)) fsm_d = S_DONE;
                else                           fsm_d = S_WAIT1;
            end
            S_DONE:  fsm_d = S_DONE;
            default: fsm_d = S_WAIT1;
        endcase
    end

    // Outputs and board bookkeeping for the coming cycle.
    always_comb begin
        cursor_d    = nxt_ok ? cursor_q + 4'd1 : cursor_q;
        select_d    = pick1 || pick2;
        card_d      = select_d ? cur_id : card_q;
        idx1_d      = pick1 ? cursor_q : idx1_q;
        idx2_d      = pick2 ? cursor_q : idx2_q;
        matched_d   = matched_upd;
        player_d    = player_q ^ ((resolve_go && !pair_eq) || to_hit);
        game_over_d = game_over_q || res_end;
        tie_d       = tie_q || (res_end && bus.res[0]);

        shown_d = shown_q;
        if (select_d) shown_d[cursor_q] = 1'b1;
        if (resolve_go && !pair_eq) begin
            shown_d[idx1_q] = 1'b0;
            shown_d[idx2_q] = 1'b0;
        end
        // A timeout in WAIT2 hides the card that was turned this turn.
        if (to_hit && (fsm_q == S_WAIT2)) shown_d[idx1_q] = 1'b0;

        tmr_d = tmr_q;
        if ((fsm_d == S_SHOW) && (fsm_q != S_SHOW))
            tmr_d = SHOW_LOAD;
        else if (((fsm_d == S_WAIT1) || (fsm_d == S_WAIT2)) &&
                 ((fsm_d != fsm_q) || to_hit || nxt_ok))
            tmr_d = TO_LOAD;
        else if ((in_wait || (fsm_q == S_SHOW)) && (tmr_q != 32'd0))
            tmr_d = tmr_q - 32'd1;
    end

    assign bus.select    = select_q;
    assign bus.state     = card_q;
    assign bus.empty     = select_q;
    assign bus.player    = player_q;
    assign bus.cursor    = cursor_q;
    assign bus.shown     = shown_q;
    assign bus.matched   = matched_q;
    assign bus.game_over = game_over_q;
    assign bus.tie       = tie_q;
endmodule
